mod_n_code_counter: RTL and testbench

- Parametrised multi-digit modulo-N counter. It generalises the team's single-digit decade counter with four things: a configurable modulus, a configurable digit count, up/down counting, and a runtime-selectable output code.
- Each digit counts 0..MODULUS-1 with ripple carry or borrow into the next digit.
- Outputs are a raw binary digit vector and an encoded digit vector. The encoded vector drives display and decoder logic downstream.
- It sits in the lab timing and display path alongside the existing counters.

---
 rtl/mod_n_code_counter.sv | 104 ++++++++++
 tb/tb_mod_n_code_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_code_counter.sv
// Multi-digit modulo-N up/down counter with ripple carry/borrow between digits
// and a registered, runtime-selectable per-digit output code.
module mod_n_code_counter #(
  parameter int unsigned N_DIGITS = 2,
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned MODULUS  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         up,
  input  logic                         load,
  input  logic [N_DIGITS*DIGIT_W-1:0]  load_val,
  input  logic [1:0]                   mode,
  output logic [N_DIGITS*DIGIT_W-1:0]  bin,
  output logic [N_DIGITS*DIGIT_W-1:0]  count,
  output logic                         tc,
  output logic                         wrap
);

  localparam int unsigned BUS_W    = N_DIGITS * DIGIT_W;
  localparam int unsigned EXT_W    = DIGIT_W + 1;
  localparam logic [EXT_W-1:0] MOD_X = EXT_W'(MODULUS);
  localparam logic [EXT_W-1:0] MAX_X = EXT_W'(MODULUS - 1);
  localparam bit   USE_2421        = (MODULUS <= 10) && (DIGIT_W >= 4);

  logic [BUS_W-1:0] bin_q, bin_d;
  logic [BUS_W-1:0] count_q, count_d;
  logic             wrap_q;
  logic             all_term;
  logic             carry;
  logic [EXT_W-1:0] dig_x, ld_x, nxt_x;

  // Per-digit output code; 2421 falls back to binary when it cannot represent the digit range.
  function automatic logic [DIGIT_W-1:0] encode(input logic [DIGIT_W-1:0] v,
                                                input logic [1:0]         m);
    logic [EXT_W-1:0] ext;
    ext = {1'b0, v};
    case (m)
      2'd0:    encode = v;
      2'd1:    encode = v ^ (v >> 1);
      2'd2:    encode = DIGIT_W'(ext + EXT_W'(3));
      default: begin
        if (USE_2421 && (ext >= EXT_W'(5))) encode = DIGIT_W'(ext + EXT_W'(6));
        else                                encode = v;
      end
    endcase
  endfunction

  // Next digit values: load legalises each field, counting ripples carry/borrow upward.
  always_comb begin
    bin_d    = bin_q;
    count_d  = '0;
    all_term = 1'b1;
    carry    = 1'b1;
    dig_x    = '0;
    ld_x     = '0;
    nxt_x    = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      dig_x = {1'b0, bin_q[i*DIGIT_W +: DIGIT_W]};
      ld_x  = {1'b0, load_val[i*DIGIT_W +: DIGIT_W]};
      nxt_x = dig_x;
      if (up) all_term = all_term & (dig_x == MAX_X);
      else    all_term = all_term & (dig_x == '0);
      if (load) begin
        nxt_x = (ld_x >= MOD_X) ? '0 : ld_x;
      end else if (en && carry) begin
        if (up) begin
          nxt_x = dig_x + EXT_W'(1);
          if (nxt_x >= MOD_X) nxt_x = '0;
          else                carry = 1'b0;
        end else begin
          if (dig_x == '0) begin
            nxt_x = MAX_X;
          end else begin
            nxt_x = dig_x - EXT_W'(1);
            carry = 1'b0;
          end
        end
      end
      bin_d[i*DIGIT_W +: DIGIT_W]   = nxt_x[DIGIT_W-1:0];
      count_d[i*DIGIT_W +: DIGIT_W] = encode(nxt_x[DIGIT_W-1:0], mode);
    end
  end

  assign tc = en & ~load & ~rst & all_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      count_q <= count_d;
      wrap_q  <= tc;
    end
  end

  assign bin   = bin_q;
  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mod_n_code_counter.sv
// Directed bench for two counter configurations (decimal 2x4b and base-6 3x3b),
// checked against an integer-valued reference model through a scoreboard queue.
module tb_mod_n_code_counter;

  localparam int unsigned NA = 2, WA = 4, MA = 10;
  localparam int unsigned NB = 3, WB = 3, MB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, en_a, up_a, load_a, tc_a, wrap_a;
  logic [NA*WA-1:0]  load_val_a, bin_a, count_a;
  logic [1:0]        mode_a;
  logic              rst_b, en_b, up_b, load_b, tc_b, wrap_b;
  logic [NB*WB-1:0]  load_val_b, bin_b, count_b;
  logic [1:0]        mode_b;

  mod_n_code_counter #(.N_DIGITS(NA), .DIGIT_W(WA), .MODULUS(MA)) u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .load(load_a),
    .load_val(load_val_a), .mode(mode_a), .bin(bin_a), .count(count_a),
    .tc(tc_a), .wrap(wrap_a)
  );

  mod_n_code_counter #(.N_DIGITS(NB), .DIGIT_W(WB), .MODULUS(MB)) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .load(load_b),
    .load_val(load_val_b), .mode(mode_b), .bin(bin_b), .count(count_b),
    .tc(tc_b), .wrap(wrap_b)
  );

  typedef struct {
    int    sel;
    int    bin;
    int    cnt;
    bit    wrap;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   val [2];

  function automatic int ndig(input int s); return (s != 0) ? NB : NA; endfunction
  function automatic int wdig(input int s); return (s != 0) ? WB : WA; endfunction
  function automatic int mdig(input int s); return (s != 0) ? MB : MA; endfunction

  function automatic int enc_digit(input int v, input int w, input int m, input int md);
    int r;
    case (md)
      0:       r = v;
      1:       r = v ^ (v >> 1);
      2:       r = (v + 3) % (1 << w);
      default: r = ((m <= 10) && (w >= 4) && (v >= 5)) ? v + 6 : v;
    endcase
    return r & ((1 << w) - 1);
  endfunction

  // Integer counter value -> packed digit bus, optionally encoded.
  function automatic int pack(input int s, input int v, input int md, input bit enc);
    int r = 0, pw = 1, d;
    for (int i = 0; i < ndig(s); i++) begin
      d  = (v / pw) % mdig(s);
      r |= (enc ? enc_digit(d, wdig(s), mdig(s), md) : d) << (wdig(s) * i);
      pw *= mdig(s);
    end
    return r;
  endfunction

  function automatic int legalize(input int s, input int lv);
    int v = 0, pw = 1, f;
    for (int i = 0; i < ndig(s); i++) begin
      f = (lv >> (wdig(s) * i)) & ((1 << wdig(s)) - 1);
      if (f >= mdig(s)) f = 0;
      v += f * pw;
      pw *= mdig(s);
    end
    return v;
  endfunction

  task automatic check_out();
    exp_t        x;
    logic [31:0] ob, oc;
    logic        ow;
    x  = sb.pop_front();
    ob = (x.sel != 0) ? 32'(bin_b)   : 32'(bin_a);
    oc = (x.sel != 0) ? 32'(count_b) : 32'(count_a);
    ow = (x.sel != 0) ? wrap_b       : wrap_a;
    checks++;
    assert (ob === 32'(x.bin)) else begin
      errors++;
      $error("FAIL %s bin: observed %0h expected %0h", x.tag, ob, x.bin);
    end
    checks++;
    assert (oc === 32'(x.cnt)) else begin
      errors++;
      $error("FAIL %s count: observed %0h expected %0h", x.tag, oc, x.cnt);
    end
    checks++;
    assert (ow === x.wrap) else begin
      errors++;
      $error("FAIL %s wrap: observed %0b expected %0b", x.tag, ow, x.wrap);
    end
  endtask

  // One clock of stimulus: drive, check combinational tc, advance model, check registers.
  task automatic step(input int s, input bit r, input bit ld, input int lv,
                      input bit e, input bit u, input int md, input string tag);
    exp_t x;
    int   span;
    bit   tc_exp;
    logic ot;
    @(negedge clk);
    if (s == 0) begin
      rst_a = r; load_a = ld; load_val_a = 8'(lv); en_a = e; up_a = u; mode_a = 2'(md);
    end else begin
      rst_b = r; load_b = ld; load_val_b = 9'(lv); en_b = e; up_b = u; mode_b = 2'(md);
    end
    span   = 1;
    for (int i = 0; i < ndig(s); i++) span *= mdig(s);
    tc_exp = e && !ld && !r && (val[s] == (u ? span - 1 : 0));
    #1;
    ot = (s != 0) ? tc_b : tc_a;
    checks++;
    assert (ot === tc_exp) else begin
      errors++;
      $error("FAIL %s tc: observed %0b expected %0b", tag, ot, tc_exp);
    end
    x.wrap = 1'b0;
    if (r)        val[s] = 0;
    else if (ld)  val[s] = legalize(s, lv);
    else if (e) begin
      x.wrap = tc_exp;
      val[s] = u ? (val[s] + 1) % span : (val[s] + span - 1) % span;
    end
    x.sel = s;
    x.bin = pack(s, val[s], 0, 1'b0);
    x.cnt = r ? 0 : pack(s, val[s], md, 1'b1);
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  int wrap_cnt;
  int first_wrap;

  initial begin
    rst_a = 1'b0; en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; load_val_a = '0; mode_a = '0;
    rst_b = 1'b0; en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; load_val_b = '0; mode_b = '0;
    val[0] = 0;
    val[1] = 0;

    // Decimal up-count through a full wrap
    step(0, 1, 0, 0, 0, 1, 0, "reset_a");
    wrap_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 0, 1, 1, 0, "up_count");
      wrap_cnt += int'(wrap_a);
    end
    checks++;
    assert (wrap_cnt == 1) else begin
      errors++;
      $error("FAIL wrap_once: observed %0d expected 1", wrap_cnt);
    end

    // Down wrap from 00 to 99
    step(0, 0, 1, 8'h00, 0, 1, 0, "load_00");
    step(0, 0, 0, 0, 1, 0, 0, "down_wrap");
    step(0, 0, 0, 0, 1, 0, 0, "down_step");

    // Output codes for digit value 7
    step(0, 0, 1, 8'h77, 0, 1, 0, "load_77");
    step(0, 0, 0, 0, 0, 1, 0, "mode_bin");
    step(0, 0, 0, 0, 0, 1, 1, "mode_gray");
    step(0, 0, 0, 0, 0, 1, 2, "mode_xs3");
    step(0, 0, 0, 0, 0, 1, 3, "mode_2421");

    // Load beats enable, illegal field clears; reset beats load
    step(0, 0, 1, 8'hC5, 1, 1, 3, "load_illegal");
    step(0, 1, 1, 8'hC5, 1, 1, 0, "rst_over_load");

    // Direction flip while counting: tc follows the new direction
    step(0, 0, 1, 8'h98, 0, 1, 0, "load_98");
    step(0, 0, 0, 0, 1, 1, 0, "up_to_99");
    step(0, 0, 0, 0, 1, 0, 0, "flip_down");
    step(0, 0, 0, 0, 1, 1, 0, "flip_up");
    step(0, 0, 0, 0, 1, 1, 0, "up_wrap");

    // Reset mid-count in excess-3 mode
    step(0, 0, 1, 8'h40, 0, 1, 2, "load_40");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1, 2, "count_to_46");
    step(0, 1, 0, 0, 1, 1, 2, "rst_mid");
    step(0, 0, 0, 0, 0, 1, 2, "idle_xs3");

    // Base-6, three-digit config in mode 3 (binary fallback)
    step(1, 1, 0, 0, 0, 1, 3, "reset_b");
    first_wrap = -1;
    for (int i = 1; i <= 216; i++) begin
      step(1, 0, 0, 0, 1, 1, 3, "b_up");
      if (wrap_b === 1'b1 && first_wrap < 0) first_wrap = i;
    end
    checks++;
    assert (first_wrap == 216) else begin
      errors++;
      $error("FAIL b_wrap_period: observed %0d expected 216", first_wrap);
    end
    step(1, 0, 1, 9'o765, 1, 1, 2, "b_load_illegal");
    step(1, 0, 0, 0, 1, 0, 1, "b_down_gray");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
